// File: rtl/surf_dout_deframer.sv
// rtl/surf_dout_deframer.sv - SURF dout byte-stream deframer with AXI4-Stream output
//
// Receive-side endpoint of the SURF event readout link. Generates the phase
// strobe that paces the transmitter, parses each event's 4-byte header, packs
// payload bytes into 32-bit words and hands them to an AXI4-Stream master
// through a small first-word-fall-through FIFO.
//
// Optional feature macro: DEFRAMER_SEQCHK_EN builds the event-number sequence
// checker; without it err_seq_o is constant 0.
//
// Parameters:
//   EVENT_BYTES  payload bytes per event (multiple of 4, >= 4)
//   FIFO_DEPTH   output FIFO depth in words (power of 2, >= 2)
//
// Ports:
//   ifclk_i            clock
//   ifclk_rst_i        synchronous active-high reset
//   dout_data_i        event byte from the link
//   dout_data_valid_i  high for the whole event
//   dout_data_phase_o  byte strobe; a byte is taken when valid && phase
//   m_axis_tdata       output word
//   m_axis_tvalid      output word valid
//   m_axis_tready      downstream ready
//   m_axis_tlast       last word of an event
//   evcount_o          completed event count (wraps)
//   err_trunc_o        sticky: event ended short
//   err_long_o         sticky: event ran past its length
//   err_ovf_o          sticky: FIFO overflow
//   err_seq_o          sticky: event number out of sequence
//   err_clr_i          one-cycle clear of all sticky flags

module surf_dout_deframer #(
    parameter int EVENT_BYTES = 3072,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        ifclk_i,
    input  logic        ifclk_rst_i,
    input  logic [7:0]  dout_data_i,
    input  logic        dout_data_valid_i,
    output logic        dout_data_phase_o,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] evcount_o,
    output logic        err_trunc_o,
    output logic        err_long_o,
    output logic        err_ovf_o,
    output logic        err_seq_o,
    input  logic        err_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(EVENT_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(EVENT_BYTES - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_PAY     = 2'd2,
        S_WAITLOW = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_phase;
    logic [CW-1:0]  r_idx;
    logic [31:0]    r_word;
    logic           r_wr_en;
    logic [31:0]    r_wr_data;
    logic           r_wr_last;
    logic [15:0]    r_evcount;
    logic           r_err_trunc;
    logic           r_err_long;
    logic           r_err_ovf;

    logic           w_sample;
    logic [1:0]     w_lane;
    logic [31:0]    w_word_next;

    assign w_sample = dout_data_valid_i && r_phase;

    // Byte lane for the incoming byte. The header is big-endian (first byte
    // lands in [31:24]); payload is little-endian (first byte in [7:0]).
    // In IDLE the word starts fresh with the first header byte.
    always_comb begin
        w_lane      = r_idx[1:0];
        w_word_next = r_word;
        case (r_state)
            S_IDLE: begin
                w_lane      = 2'd3;
                w_word_next = 32'd0;
            end
            S_HDR:   w_lane = ~r_idx[1:0];
            default: w_lane = r_idx[1:0];
        endcase
        w_word_next[{w_lane, 3'b000} +: 8] = dout_data_i;
    end

    // Parser FSM. Word writes are registered into r_wr_* and land in the FIFO
    // on the following edge. r_word only ever holds the bytes of the word in
    // progress with unused lanes zero, so a truncation flush writes it as-is
    // (an all-zero word when no partial bytes exist).
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_idx       <= '0;
            r_word      <= 32'd0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= 32'd0;
            r_wr_last   <= 1'b0;
            r_evcount   <= 16'd0;
            r_err_trunc <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            r_wr_en <= 1'b0;

            // Clear first so a same-cycle set below wins.
            if (err_clr_i) begin
                r_err_trunc <= 1'b0;
                r_err_long  <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_sample) begin
                        r_word  <= w_word_next;
                        r_idx   <= CW'(1);
                        r_state <= S_HDR;
                    end
                end

                S_HDR, S_PAY: begin
                    if (!dout_data_valid_i) begin
                        r_wr_en     <= 1'b1;
                        r_wr_data   <= r_word;
                        r_wr_last   <= 1'b1;
                        r_evcount   <= r_evcount + 16'd1;
                        r_err_trunc <= 1'b1;
                        r_word      <= 32'd0;
                        r_idx       <= '0;
                        r_state     <= S_IDLE;
                    end else if (w_sample) begin
                        if (r_idx[1:0] == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_word_next;
                            r_word    <= 32'd0;
                            if (r_state == S_HDR) begin
                                r_wr_last <= 1'b0;
                                r_idx     <= '0;
                                r_state   <= S_PAY;
                            end else if (r_idx == LAST_IDX) begin
                                r_wr_last <= 1'b1;
                                r_evcount <= r_evcount + 16'd1;
                                r_idx     <= '0;
                                r_state   <= S_WAITLOW;
                            end else begin
                                r_wr_last <= 1'b0;
                                r_idx     <= r_idx + 1'b1;
                            end
                        end else begin
                            r_word <= w_word_next;
                            r_idx  <= r_idx + 1'b1;
                        end
                    end
                end

                S_WAITLOW: begin
                    if (!dout_data_valid_i) begin
                        r_state <= S_IDLE;
                    end else if (w_sample) begin
                        r_err_long <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DEFRAMER_SEQCHK_EN
    logic        w_hdr_done;
    logic [15:0] w_hdr_evno;
    logic [15:0] r_seq_exp;
    logic        r_seq_loaded;
    logic        r_err_seq;

    assign w_hdr_done = (r_state == S_HDR) && w_sample && (r_idx[1:0] == 2'd3);
    assign w_hdr_evno = w_word_next[31:16];

    // The first complete header after reset or a clear only primes the
    // expected number; later headers are compared against it.
    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_seq_exp    <= 16'd0;
            r_seq_loaded <= 1'b0;
            r_err_seq    <= 1'b0;
        end else begin
            if (err_clr_i) begin
                r_err_seq    <= 1'b0;
                r_seq_loaded <= 1'b0;
            end
            if (w_hdr_done) begin
                r_seq_exp    <= w_hdr_evno + 16'd1;
                r_seq_loaded <= 1'b1;
                if (r_seq_loaded && !err_clr_i && (w_hdr_evno != r_seq_exp)) begin
                    r_err_seq <= 1'b1;
                end
            end
        end
    end

    assign err_seq_o = r_err_seq;
`else
    assign err_seq_o = 1'b0;
`endif

    // Output FWFT FIFO: {tlast, tdata} per entry.
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_rd;
    logic          w_wr_ok;
    logic [32:0]   w_head;

    assign w_full  = (r_count == DEPTH_L);
    assign w_rd    = m_axis_tvalid && m_axis_tready;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_wr_ok = r_wr_en && (!w_full || w_rd);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge ifclk_i) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= {r_wr_last, r_wr_data};
        end
    end

    always_ff @(posedge ifclk_i) begin
        if (ifclk_rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_ok, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (err_clr_i) begin
                r_err_ovf <= 1'b0;
            end
            if (r_wr_en && !w_wr_ok) begin
                r_err_ovf <= 1'b1;
            end
        end
    end

    // Memory is not reset, so gate the data path to read as zero when empty.
    assign m_axis_tvalid     = (r_count != '0);
    assign m_axis_tdata      = m_axis_tvalid ? w_head[31:0] : 32'd0;
    assign m_axis_tlast      = m_axis_tvalid & w_head[32];
    assign dout_data_phase_o = r_phase;
    assign evcount_o         = r_evcount;
    assign err_trunc_o       = r_err_trunc;
    assign err_long_o        = r_err_long;
    assign err_ovf_o         = r_err_ovf;

endmodule

// File: tb/tb_surf_dout_deframer.sv
// tb/tb_surf_dout_deframer.sv - directed self-checking bench for surf_dout_deframer

module tb_surf_dout_deframer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  data;
    logic        valid;
    logic        err_clr;
    logic        tready;
    logic        tready_b;

    logic        phase,  phase_b;
    logic [31:0] tdata,  tdata_b;
    logic        tvalid, tvalid_b;
    logic        tlast,  tlast_b;
    logic [15:0] evcount, evcount_b;
    logic        err_trunc, err_trunc_b;
    logic        err_long,  err_long_b;
    logic        err_ovf,   err_ovf_b;
    logic        err_seq,   err_seq_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_buf [0:31];
    logic [32:0] rxq   [$];
    logic [32:0] rxq_b [$];

    surf_dout_deframer #(.EVENT_BYTES(8), .FIFO_DEPTH(16)) u_dut (
        .ifclk_i(clk), .ifclk_rst_i(rst),
        .dout_data_i(data), .dout_data_valid_i(valid), .dout_data_phase_o(phase),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .evcount_o(evcount),
        .err_trunc_o(err_trunc), .err_long_o(err_long), .err_ovf_o(err_ovf),
        .err_seq_o(err_seq), .err_clr_i(err_clr)
    );

    surf_dout_deframer #(.EVENT_BYTES(16), .FIFO_DEPTH(4)) u_bp (
        .ifclk_i(clk), .ifclk_rst_i(rst),
        .dout_data_i(data), .dout_data_valid_i(valid), .dout_data_phase_o(phase_b),
        .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b), .m_axis_tready(tready_b),
        .m_axis_tlast(tlast_b), .evcount_o(evcount_b),
        .err_trunc_o(err_trunc_b), .err_long_o(err_long_b), .err_ovf_o(err_ovf_b),
        .err_seq_o(err_seq_b), .err_clr_i(err_clr)
    );

    // Capture every accepted beat, sampled mid-low-phase.
    always begin
        @(negedge clk);
        #2;
        if (tvalid && tready)     rxq.push_back({tlast, tdata});
        if (tvalid_b && tready_b) rxq_b.push_back({tlast_b, tdata_b});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic load_event(input logic [15:0] evno, input logic [15:0] tt,
                              input logic [7:0] first, input int npay);
        tx_buf[0] = evno[15:8];
        tx_buf[1] = evno[7:0];
        tx_buf[2] = tt[15:8];
        tx_buf[3] = tt[7:0];
        for (int k = 0; k < npay; k++) tx_buf[4 + k] = first + 8'(k);
    endtask

    // Present bytes first..last; each byte is held until a phase-high cycle.
    task automatic send_bytes(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            data  = tx_buf[i];
            valid = 1'b1;
            if (!phase) @(negedge clk);
        end
    endtask

    task automatic end_event();
        @(negedge clk);
        valid = 1'b0;
        data  = 8'h00;
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rxq.delete();
        rxq_b.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = 8'h00; err_clr = 1'b0;
        tready = 1'b1; tready_b = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({phase, tvalid, tdata, tlast, evcount, err_trunc, err_long, err_ovf, err_seq} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {phase, tvalid, tdata, tlast, evcount, err_trunc, err_long, err_ovf, err_seq});
        end
        @(negedge clk);
        checks++;
        if (phase !== 1'b1) begin
            failures++;
            $display("FAIL phase_toggle1 got=%b exp=1", phase);
        end
        @(negedge clk);
        checks++;
        if (phase !== 1'b0) begin
            failures++;
            $display("FAIL phase_toggle2 got=%b exp=0", phase);
        end
    endtask

    task automatic test_nominal();
        logic [32:0] exp [3];
        exp = '{{1'b0, 32'h01020304}, {1'b0, 32'h13121110}, {1'b1, 32'h17161514}};
        load_event(16'h0102, 16'h0304, 8'h10, 8);
        rxq.delete();
        send_bytes(0, 3);
        @(negedge clk);
        data = tx_buf[4];
        checks++;
        if (tvalid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early tvalid got=%b exp=0", tvalid);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h01020304) begin
            failures++;
            $display("FAIL latency_word tvalid/tdata got=%b/%h exp=1/01020304", tvalid, tdata);
        end
        send_bytes(5, 11);
        end_event();
        checks++;
        if (rxq.size() != 3) begin
            failures++;
            $display("FAIL nominal_count got=%0d exp=3", rxq.size());
        end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== exp[i]) begin
                failures++;
                $display("FAIL nominal_word%0d got=%h exp=%h", i, rxq[i], exp[i]);
            end
        end
        checks++;
        if ({evcount, err_trunc, err_long, err_ovf, err_seq} !== {16'd1, 4'b0000}) begin
            failures++;
            $display("FAIL nominal_status got=%h exp=%h",
                     {evcount, err_trunc, err_long, err_ovf, err_seq}, {16'd1, 4'b0000});
        end
    endtask

    task automatic test_truncation();
        logic [32:0] exp [3];
        exp = '{{1'b0, 32'h01020304}, {1'b0, 32'h13121110}, {1'b1, 32'h00000014}};
        load_event(16'h0102, 16'h0304, 8'h10, 5);
        rxq.delete();
        send_bytes(0, 8);
        end_event();
        checks++;
        if (rxq.size() != 3) begin
            failures++;
            $display("FAIL trunc_count got=%0d exp=3", rxq.size());
        end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== exp[i]) begin
                failures++;
                $display("FAIL trunc_word%0d got=%h exp=%h", i, rxq[i], exp[i]);
            end
        end
        checks++;
        if (err_trunc !== 1'b1 || evcount !== 16'd2) begin
            failures++;
            $display("FAIL trunc_status err_trunc/evcount got=%b/%0d exp=1/2", err_trunc, evcount);
        end
    endtask

    task automatic test_long();
        logic [32:0] exp [3];
        exp = '{{1'b0, 32'h01020304}, {1'b0, 32'h13121110}, {1'b1, 32'h17161514}};
        pulse_clr();
        checks++;
        if (err_trunc !== 1'b0) begin
            failures++;
            $display("FAIL clr_trunc got=%b exp=0", err_trunc);
        end
        for (int pass = 0; pass < 2; pass++) begin
            load_event(16'h0102, 16'h0304, 8'h10, 8);
            tx_buf[12] = 8'hAA;
            tx_buf[13] = 8'hBB;
            rxq.delete();
            send_bytes(0, (pass == 0) ? 13 : 11);
            end_event();
            checks++;
            if (rxq.size() != 3) begin
                failures++;
                $display("FAIL long%0d_count got=%0d exp=3", pass, rxq.size());
            end
            for (int i = 0; i < 3 && i < rxq.size(); i++) begin
                checks++;
                if (rxq[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL long%0d_word%0d got=%h exp=%h", pass, i, rxq[i], exp[i]);
                end
            end
            checks++;
            if ({err_long, err_trunc, evcount} !== {2'b10, 16'(3 + pass)}) begin
                failures++;
                $display("FAIL long%0d_status long/trunc/evcount got=%b/%b/%0d exp=1/0/%0d",
                         pass, err_long, err_trunc, evcount, 3 + pass);
            end
        end
    endtask

    task automatic test_seq();
        pulse_clr();
        load_event(16'h0005, 16'h0000, 8'h20, 8);
        send_bytes(0, 11);
        end_event();
        load_event(16'h0007, 16'h0000, 8'h20, 8);
        send_bytes(0, 11);
        end_event();
        checks++;
        if (evcount !== 16'd6) begin
            failures++;
            $display("FAIL seq_evcount got=%0d exp=6", evcount);
        end
`ifdef DEFRAMER_SEQCHK_EN
        checks++;
        if (err_seq !== 1'b1) begin
            failures++;
            $display("FAIL seq_detect got=%b exp=1", err_seq);
        end
        pulse_clr();
        checks++;
        if (err_seq !== 1'b0) begin
            failures++;
            $display("FAIL seq_clear got=%b exp=0", err_seq);
        end
        load_event(16'h0008, 16'h0000, 8'h20, 8);
        send_bytes(0, 11);
        end_event();
        checks++;
        if (err_seq !== 1'b0) begin
            failures++;
            $display("FAIL seq_after_clear got=%b exp=0", err_seq);
        end
`else
        checks++;
        if (err_seq !== 1'b0) begin
            failures++;
            $display("FAIL seq_disabled got=%b exp=0", err_seq);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [32:0] exp [4];
        exp = '{{1'b0, 32'h01020304}, {1'b0, 32'h13121110},
                {1'b0, 32'h17161514}, {1'b0, 32'h1B1A1918}};
        apply_reset();
        tready_b = 1'b0;
        load_event(16'h0102, 16'h0304, 8'h10, 16);
        send_bytes(0, 19);
        end_event();
        checks++;
        if (err_ovf_b !== 1'b1 || rxq_b.size() != 0 || tvalid_b !== 1'b1) begin
            failures++;
            $display("FAIL bp_stalled ovf/captured/tvalid got=%b/%0d/%b exp=1/0/1",
                     err_ovf_b, rxq_b.size(), tvalid_b);
        end
        checks++;
        if (evcount_b !== 16'd1 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_evcount/main_ovf got=%0d/%b exp=1/0", evcount_b, err_ovf);
        end
        @(negedge clk);
        tready_b = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rxq_b.size() != 4 || tvalid_b !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain_count got=%0d tvalid=%b exp=4 tvalid=0", rxq_b.size(), tvalid_b);
        end
        for (int i = 0; i < 4 && i < rxq_b.size(); i++) begin
            checks++;
            if (rxq_b[i] !== exp[i]) begin
                failures++;
                $display("FAIL bp_word%0d got=%h exp=%h", i, rxq_b[i], exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        @(negedge clk);
        force u_dut.r_evcount = 16'hFFFF;
        @(negedge clk);
        release u_dut.r_evcount;
        load_event(16'h0102, 16'h0304, 8'h10, 8);
        send_bytes(0, 11);
        end_event();
        checks++;
        if (evcount !== 16'h0000 || rxq.size() != 3) begin
            failures++;
            $display("FAIL wrap_evcount got=%h words=%0d exp=0000 words=3", evcount, rxq.size());
        end
    endtask

    task automatic test_reset_mid();
        rxq.delete();
        load_event(16'h0102, 16'h0304, 8'h10, 3);
        send_bytes(0, 6);
        end_event();
        checks++;
        if (evcount !== 16'd1 || err_trunc !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset evcount/trunc got=%0d/%b exp=1/1", evcount, err_trunc);
        end
        send_bytes(0, 6);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tvalid, tdata, tlast, evcount, err_trunc, err_long, err_ovf} !== 53'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0",
                     {tvalid, tdata, tlast, evcount, err_trunc, err_long, err_ovf});
        end
        repeat (12) @(negedge clk);
        checks++;
        if (rxq.size() != 3 || tvalid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_count got=%0d tvalid=%b exp=3 tvalid=0", rxq.size(), tvalid);
        end else begin
            checks++;
            if (rxq[1] !== {1'b1, 32'h00121110} || rxq[2] !== {1'b0, 32'h01020304}) begin
                failures++;
                $display("FAIL midreset_words got=%h,%h exp=100121110,001020304", rxq[1], rxq[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_truncation();
        test_long();
        test_seq();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/surf_dout_deframer.md
# surf_dout_deframer

Receive-side endpoint of the SURF event readout byte stream (`dout_data` / `dout_data_valid` / `dout_data_phase`). It lives in the `ifclk` domain at the far end of the link and drives the phase strobe that paces the transmitter. It parses each event's 4-byte header, packs the payload bytes into 32-bit words, and presents them on an AXI4-Stream master through a small first-word-fall-through (FWFT) FIFO. Framing, sequence and overflow errors are reported as sticky flags.

## Interface
- `EVENT_BYTES`, 3072: payload bytes per event, excluding the header. Must be a multiple of 4 and ≥4.
- `FIFO_DEPTH`, 16: output FIFO depth in 32-bit words. Must be a power of 2.

- `ifclk_i` in 1: sole clock.
- `ifclk_rst_i` in 1: reset. Synchronous, active-high.
- `dout_data_i` in 8: event byte.
- `dout_data_valid_i` in 1: high for the whole event (header plus payload).
- `dout_data_phase_o` out 1: byte strobe; the transmitter presents a new byte on each cycle where this is high.
- `m_axis_tdata` out 32: output word.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: marks the final word of an event.
- `evcount_o` out 16: count of completed events; wraps.
- `err_trunc_o` out 1: sticky; an event ended short.
- `err_long_o` out 1: sticky; an event ran past its length.
- `err_ovf_o` out 1: sticky; the FIFO overflowed.
- `err_seq_o` out 1: sticky; event number out of sequence. Only present with `DEFRAMER_SEQCHK_EN`; otherwise tied 0.
- `err_clr_i` in 1: one-cycle pulse that clears all sticky flags.

## Operation
- **Phase strobe:** `dout_data_phase_o` toggles every cycle and is 0 in the first cycle after reset. A byte is *sampled* only on a cycle where `dout_data_valid_i && dout_data_phase_o`.
- **Byte order:** header bytes arrive in this order: `event_no[15:8]`, `event_no[7:0]`, `trig_time[15:8]`, `trig_time[7:0]`.
  - Header word: `{event_no, trig_time}`.
  - Payload words are little-endian: the first byte of each group of four goes to `[7:0]`.
- **State machine:**
  - IDLE: the first sample moves to HDR; the byte index is cleared and that first byte is counted.
  - HDR: after 4 header bytes, write the header word and move to PAY.
  - PAY: write a word every 4 bytes. After byte `EVENT_BYTES`, write the final word with tlast, increment `evcount_o`, and move to WAITLOW.
  - WAITLOW: stay while `dout_data_valid_i` is 1. Any sample here sets `err_long_o` and the byte is discarded. Move to IDLE when valid is 0.
  - Valid falling in HDR or PAY: the partial word is zero-padded to the high bytes and written with tlast. If there is no partial word, the last complete word already written had no tlast, so a zero word with tlast is written instead. `err_trunc_o` is set, `evcount_o` increments, and the state goes to IDLE.
    - A truncation inside HDR emits the zero-padded header word with tlast.
- **FIFO write rules:**
  - A word written while the FIFO is full is dropped and sets `err_ovf_o`. This includes tlast words.
  - Parsing never stalls, because the input has no backpressure.
- **Counters and flags:**
  - `evcount_o` is 16-bit and wraps from 0xFFFF to 0x0000.
  - If a flag sets in the same cycle as `err_clr_i`, the flag ends set.

## Timing
- Reset values: all outputs are 0, and the FIFO is empty. Reset mid-event abandons the event; no tlast is produced.
- Word write happens in the cycle after the 4th byte of the word is sampled. `m_axis_tvalid` rises in the cycle after the write, so a word appears 2 cycles after its last byte is sampled.
- Truncation flush: the word is written in the cycle after valid is seen low.
- AXI handshake:
  - A word transfers on `tvalid && tready`.
  - `tdata` and `tlast` hold while `tvalid && !tready`.
  - A simultaneous write and read on a full FIFO is not an overflow.
- Throughput: at most 1 word per 8 cycles, so `tready` held high never overflows.

## Configuration
- `DEFRAMER_SEQCHK_EN` defined:
  - Each header's `event_no` is compared to the expected number, which is the previous `event_no` + 1, wrapping at 16 bits.
  - A mismatch sets `err_seq_o`.
  - The first event after reset, or after `err_clr_i`, loads the expected number without checking.
- `DEFRAMER_SEQCHK_EN` undefined: no comparator is built, and `err_seq_o` is constant 0.

## Test plan
- **Nominal event** with `EVENT_BYTES`=8: event_no 0x0102, trig_time 0x0304, bytes 0x10..0x17 → words 0x01020304, 0x13121110, then 0x17161514 with tlast; `evcount_o`=1; no flags.
- **Truncation:** valid drops after header plus 5 payload bytes (0x10..0x14) → 0x01020304, 0x13121110, then 0x00000014 with tlast; `err_trunc_o`=1.
- **Long event:** 2 extra bytes after the final payload byte → same 3 words as the nominal event; `err_long_o`=1; the next event parses normally.
- **Backpressure:** `tready`=0 with `FIFO_DEPTH`=4, `EVENT_BYTES`=16 → first 4 words retained, 5th dropped, `err_ovf_o`=1; releasing `tready` drains exactly 4 words in order.
- **Sequence check** (with `DEFRAMER_SEQCHK_EN`): event_no 5 then 7 → `err_seq_o`=1 after the second header; `err_clr_i` clears it; next event 8 leaves it 0.
- **Wrap and reset:** preload 0xFFFF events → `evcount_o`=0x0000 after the next one. `ifclk_rst_i` mid-PAY → outputs 0, FIFO empty, no tlast emitted.
